// File: rtl/quad_decoder_cntrl.sv
// Quadrature encoder front end: synchronises and glitch-filters A/B/index, then
// turns legal Gray-code steps and index edges into one-cycle counter control pulses.
module quad_decoder_cntrl #(
    parameter int DWIDTH      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3,
    parameter int LOAD_VALUE  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enc_a,
    input  logic              enc_b,
    input  logic              enc_idx,
    input  logic              idx_ena,
    input  logic              err_clr,
    output logic              cntrl__up_dwn,
    output logic              cntrl__load,
    output logic              cntrl__ena,
    output logic [DWIDTH-1:0] cntrl__data_in,
    output logic              err_pulse,
    output logic              err_sticky
);
    localparam int CW  = $clog2(FILT_LEN + 1);
    localparam int NCH = 3;

    typedef enum logic {IDX_ARMED, IDX_WAIT_LOW} idx_state_e;

    logic [NCH-1:0]         raw;
    logic [SYNC_STAGES-1:0] sync_q [NCH];
    logic [CW-1:0]          fcnt_q [NCH];
    logic [NCH-1:0]         filt_q;

    logic [1:0] prev_q;
    logic [1:0] ab_cur;
    logic [1:0] pos_prev;
    logic [1:0] pos_cur;
    logic [1:0] delta;

    logic ena_d, up_d, err_d, sticky_d;
    logic ena_q, up_q, err_q, sticky_q, load_q;
    idx_state_e idx_state_q;

    // Channel order: 0 = A, 1 = B, 2 = index.
    assign raw = {enc_idx, enc_b, enc_a};

    // Once the counter has seen FILT_LEN disagreeing cycles the filtered value
    // flips, even if the synchronised input has just returned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                sync_q[i] <= '0;
                fcnt_q[i] <= '0;
            end
            filt_q <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], raw[i]};
                if (fcnt_q[i] == CW'(FILT_LEN)) begin
                    filt_q[i] <= ~filt_q[i];
                    fcnt_q[i] <= '0;
                end else if (sync_q[i][SYNC_STAGES-1] != filt_q[i]) begin
                    fcnt_q[i] <= fcnt_q[i] + CW'(1);
                end else begin
                    fcnt_q[i] <= '0;
                end
            end
        end
    end

    // Gray {A,B} to a 2-bit position: the step is then a modulo-4 difference.
    assign ab_cur   = {filt_q[0], filt_q[1]};
    assign pos_prev = {prev_q[1], prev_q[1] ^ prev_q[0]};
    assign pos_cur  = {ab_cur[1], ab_cur[1] ^ ab_cur[0]};
    assign delta    = pos_cur - pos_prev;

    always_comb begin
        ena_d = 1'b0;
        up_d  = up_q;
        err_d = 1'b0;
        case (delta)
            2'd1: begin
                ena_d = 1'b1;
                up_d  = 1'b1;
            end
            2'd3: begin
                ena_d = 1'b1;
                up_d  = 1'b0;
            end
            2'd2:    err_d = 1'b1;
            default: ;
        endcase
        // A new error in the same cycle as a clear keeps the flag set.
        sticky_d = err_q | (sticky_q & ~err_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q   <= 2'b00;
            ena_q    <= 1'b0;
            up_q     <= 1'b1;
            err_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            prev_q   <= ab_cur;
            ena_q    <= ena_d;
            up_q     <= up_d;
            err_q    <= err_d;
            sticky_q <= sticky_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_state_q <= IDX_ARMED;
            load_q      <= 1'b0;
        end else begin
            load_q <= 1'b0;
            case (idx_state_q)
                IDX_ARMED: begin
                    if (filt_q[2]) begin
                        load_q      <= idx_ena;
                        idx_state_q <= IDX_WAIT_LOW;
                    end
                end
                IDX_WAIT_LOW: begin
                    if (!filt_q[2]) begin
                        idx_state_q <= IDX_ARMED;
                    end
                end
                default: idx_state_q <= IDX_ARMED;
            endcase
        end
    end

    assign cntrl__up_dwn  = up_q;
    assign cntrl__load    = load_q;
    assign cntrl__ena     = ena_q;
    assign cntrl__data_in = DWIDTH'(LOAD_VALUE);
    assign err_pulse      = err_q;
    assign err_sticky     = sticky_q;

endmodule

// File: tb/tb_quad_decoder_cntrl.sv
// Self-checking bench for quad_decoder_cntrl: scenario tasks plus a randomized
// step walk scored against an event-level model of the decoder.
module tb_quad_decoder_cntrl;
    localparam int DWIDTH      = 4;
    localparam int SYNC_STAGES = 2;
    localparam int FILT_LEN    = 3;
    localparam int LOAD_VALUE  = 9;
    localparam int LAT         = SYNC_STAGES + FILT_LEN + 1;
    localparam int MAXC        = 8192;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enc_a = 1'b0, enc_b = 1'b0, enc_idx = 1'b0, idx_ena = 1'b0, err_clr = 1'b0;
    logic cntrl__up_dwn, cntrl__load, cntrl__ena, err_pulse, err_sticky;
    logic [DWIDTH-1:0] cntrl__data_in;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic obs_ena [MAXC];
    logic obs_up  [MAXC];
    logic obs_ld  [MAXC];
    logic obs_err [MAXC];
    logic obs_st  [MAXC];
    bit   exp_ena [MAXC];
    bit   exp_dir [MAXC];
    bit   exp_err [MAXC];

    logic [1:0] cur_ab = 2'b00;
    bit model_dir = 1'b1;
    bit model_st  = 1'b0;
    int gpos[4]   = '{0, 1, 3, 2};
    int pos2ab[4] = '{0, 1, 3, 2};

    quad_decoder_cntrl #(
        .DWIDTH(DWIDTH), .SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN), .LOAD_VALUE(LOAD_VALUE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enc_a(enc_a), .enc_b(enc_b), .enc_idx(enc_idx),
        .idx_ena(idx_ena), .err_clr(err_clr), .cntrl__up_dwn(cntrl__up_dwn),
        .cntrl__load(cntrl__load), .cntrl__ena(cntrl__ena), .cntrl__data_in(cntrl__data_in),
        .err_pulse(err_pulse), .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cyc < MAXC) begin
            obs_ena[cyc] = cntrl__ena;
            obs_up[cyc]  = cntrl__up_dwn;
            obs_ld[cyc]  = cntrl__load;
            obs_err[cyc] = err_pulse;
            obs_st[cyc]  = err_sticky;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_exp();
        for (int k = 0; k < MAXC; k++) begin
            exp_ena[k] = 1'b0;
            exp_dir[k] = 1'b0;
            exp_err[k] = 1'b0;
        end
    endtask

    // Model: a raw A/B change sampled at the next edge shows up LAT edges later
    // as a step (position +1 up, +3 down) or an error (+2).
    task automatic drive_ab(input logic [1:0] ab);
        int d;
        int t;
        t = cyc + 1 + LAT;
        if (ab != cur_ab && t < MAXC) begin
            d = (gpos[ab] - gpos[cur_ab] + 4) % 4;
            if (d == 2) begin
                exp_err[t] = 1'b1;
            end else begin
                exp_ena[t] = 1'b1;
                exp_dir[t] = (d == 1);
            end
        end
        cur_ab = ab;
        enc_a  = ab[1];
        enc_b  = ab[0];
    endtask

    task automatic hold_ab(input logic [1:0] ab, input int n);
        tick();
        drive_ab(ab);
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        total++;
        if ({cntrl__up_dwn, cntrl__ena, cntrl__load, err_pulse, err_sticky} !== 5'b10000) begin
            bad++;
            $display("FAIL reset_hold outs=%b want 10000", {cntrl__up_dwn, cntrl__ena, cntrl__load, err_pulse, err_sticky});
        end
        rst_n = 1'b1;
        repeat (5) tick();
        total++;
        if ({cntrl__up_dwn, cntrl__ena, cntrl__load, err_pulse, err_sticky} !== 5'b10000) begin
            bad++;
            $display("FAIL reset_release outs=%b want 10000", {cntrl__up_dwn, cntrl__ena, cntrl__load, err_pulse, err_sticky});
        end
        total++;
        if (cntrl__data_in !== DWIDTH'(LOAD_VALUE)) begin
            bad++;
            $display("FAIL data_in got %0d want %0d", cntrl__data_in, LOAD_VALUE);
        end
    endtask

    task automatic test_steps(input string name, input logic [1:0] s0, input logic [1:0] s1,
                              input logic [1:0] s2, input logic [1:0] s3);
        int t0, t1;
        clear_exp();
        tick();
        t0 = cyc;
        hold_ab(s0, 10);
        hold_ab(s1, 10);
        hold_ab(s2, 10);
        hold_ab(s3, 10);
        repeat (LAT + 3) tick();
        t1 = cyc;
        for (int k = t0; k <= t1; k++) begin
            if (exp_ena[k]) model_dir = exp_dir[k];
            total++;
            if (obs_ena[k] !== exp_ena[k]) begin
                bad++;
                $display("FAIL %s ena @%0d got %b want %b", name, k, obs_ena[k], exp_ena[k]);
            end
            total++;
            if (obs_up[k] !== model_dir) begin
                bad++;
                $display("FAIL %s up_dwn @%0d got %b want %b", name, k, obs_up[k], model_dir);
            end
            total++;
            if (obs_err[k] !== 1'b0) begin
                bad++;
                $display("FAIL %s err @%0d got %b want 0", name, k, obs_err[k]);
            end
        end
    endtask

    task automatic test_glitch();
        int t0, t1, n, first, second;
        hold_ab(2'b01, 12);
        tick();
        total++;
        if (cntrl__up_dwn !== 1'b1) begin
            bad++;
            $display("FAIL glitch_setup up_dwn got %b want 1", cntrl__up_dwn);
        end
        tick();
        t0 = cyc;
        enc_a = 1'b1;
        repeat (2) tick();
        enc_a = 1'b0;
        repeat (LAT + 6) tick();
        t1 = cyc;
        n = 0;
        for (int k = t0; k <= t1; k++) n += int'(obs_ena[k] === 1'b1) + int'(obs_err[k] === 1'b1);
        total++;
        if (n != 0) begin
            bad++;
            $display("FAIL glitch2 pulses got %0d want 0", n);
        end
        tick();
        t0 = cyc;
        enc_a = 1'b1;
        repeat (3) tick();
        enc_a = 1'b0;
        repeat (LAT + 10) tick();
        t1 = cyc;
        n = 0;
        first = -1;
        second = -1;
        for (int k = t0; k <= t1; k++) begin
            if (obs_ena[k] === 1'b1) begin
                n++;
                if (first < 0) first = k;
                else if (second < 0) second = k;
            end
            if (obs_err[k] === 1'b1) n += 100;
        end
        total++;
        if (n != 2) begin
            bad++;
            $display("FAIL glitch3 pulse_count got %0d want 2", n);
        end
        total++;
        if (first != t0 + 1 + LAT || obs_up[t0 + 1 + LAT] !== 1'b1) begin
            bad++;
            $display("FAIL glitch3 first_up got cyc %0d want %0d", first, t0 + 1 + LAT);
        end
        total++;
        if (second < 0 || obs_up[second] !== 1'b0) begin
            bad++;
            $display("FAIL glitch3 second_down got cyc %0d", second);
        end
        model_dir = 1'b0;
    endtask

    task automatic test_error();
        int t0, te, t1;
        clear_exp();
        tick();
        t0 = cyc;
        te = cyc + 1 + LAT;
        drive_ab(cur_ab ^ 2'b11);
        repeat (12) tick();
        t1 = cyc;
        for (int k = t0; k <= t1; k++) begin
            total++;
            if (obs_ena[k] !== 1'b0 || obs_err[k] !== exp_err[k] || obs_up[k] !== model_dir) begin
                bad++;
                $display("FAIL error_step @%0d ena/err/up got %b%b%b want 0%b%b", k, obs_ena[k], obs_err[k], obs_up[k], exp_err[k], model_dir);
            end
            total++;
            if (obs_st[k] !== (k >= te + 1)) begin
                bad++;
                $display("FAIL error_sticky @%0d got %b want %b", k, obs_st[k], (k >= te + 1));
            end
        end
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        total++;
        if (err_sticky !== 1'b0) begin
            bad++;
            $display("FAIL err_clr sticky got %b want 0", err_sticky);
        end
        tick();
        err_clr = 1'b1;
        te = cyc + 1 + LAT;
        drive_ab(cur_ab ^ 2'b11);
        repeat (LAT + 4) tick();
        err_clr = 1'b0;
        total++;
        if ({obs_err[te], obs_st[te], obs_st[te + 1], obs_st[te + 2]} !== 4'b1010) begin
            bad++;
            $display("FAIL err_set_wins err,st0,st1,st2 got %b want 1010", {obs_err[te], obs_st[te], obs_st[te + 1], obs_st[te + 2]});
        end
        total++;
        if (cntrl__up_dwn !== model_dir) begin
            bad++;
            $display("FAIL err_dir_hold got %b want %b", cntrl__up_dwn, model_dir);
        end
        model_st = 1'b0;
    endtask

    task automatic test_index();
        for (int s = 0; s < 4; s++) begin
            int t0, t1, len, nl, first;
            bit want;
            want = (s == 0 || s == 3);
            len  = (s == 1 || s == 3) ? int'($urandom_range(FILT_LEN + 1, 30)) : 20;
            tick();
            t0 = cyc;
            idx_ena = want;
            enc_idx = 1'b1;
            for (int j = 1; j < len; j++) begin
                tick();
                if (s == 2 && j == 12) idx_ena = 1'b1;
            end
            tick();
            enc_idx = 1'b0;
            repeat (LAT + 6) tick();
            t1 = cyc;
            idx_ena = 1'b0;
            nl = 0;
            first = -1;
            for (int k = t0; k <= t1; k++) begin
                if (obs_ld[k] === 1'b1) begin
                    nl++;
                    if (first < 0) first = k;
                end
            end
            total++;
            if (nl != int'(want) || (want && first != t0 + 1 + LAT)) begin
                bad++;
                $display("FAIL index s=%0d len=%0d loads got %0d at %0d want %0d at %0d", s, len, nl, first, want, t0 + 1 + LAT);
            end
            total++;
            if (cntrl__data_in !== DWIDTH'(LOAD_VALUE)) begin
                bad++;
                $display("FAIL index data_in got %0d want %0d", cntrl__data_in, LOAD_VALUE);
            end
        end
    endtask

    task automatic test_random_walk();
        int t0, t1;
        clear_exp();
        tick();
        t0 = cyc;
        for (int s = 0; s < 40; s++) begin
            int r, p;
            logic [1:0] nab;
            r = $urandom_range(0, 9);
            p = gpos[cur_ab];
            if (r == 0) nab = cur_ab ^ 2'b11;
            else if (r < 5) nab = 2'(pos2ab[(p + 1) % 4]);
            else nab = 2'(pos2ab[(p + 3) % 4]);
            hold_ab(nab, $urandom_range(FILT_LEN + 1, 12));
        end
        repeat (LAT + 3) tick();
        t1 = cyc;
        for (int k = t0; k <= t1; k++) begin
            if (exp_ena[k]) model_dir = exp_dir[k];
            total++;
            if (obs_ena[k] !== exp_ena[k] || obs_err[k] !== exp_err[k]) begin
                bad++;
                $display("FAIL walk ena/err @%0d got %b%b want %b%b", k, obs_ena[k], obs_err[k], exp_ena[k], exp_err[k]);
            end
            total++;
            if (obs_up[k] !== model_dir) begin
                bad++;
                $display("FAIL walk up_dwn @%0d got %b want %b", k, obs_up[k], model_dir);
            end
            total++;
            if (obs_st[k] !== model_st) begin
                bad++;
                $display("FAIL walk sticky @%0d got %b want %b", k, obs_st[k], model_st);
            end
            model_st = model_st | exp_err[k];
        end
    endtask

    task automatic test_reset_mid();
        int t0, t1, n;
        hold_ab(2'(pos2ab[(gpos[cur_ab] + 3) % 4]), 12);
        hold_ab(cur_ab ^ 2'b11, 12);
        tick();
        total++;
        if (cntrl__up_dwn !== 1'b0 || err_sticky !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_setup up,sticky got %b%b want 01", cntrl__up_dwn, err_sticky);
        end
        idx_ena = 1'b1;
        enc_idx = 1'b1;
        enc_a = ~enc_a;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        total++;
        if ({cntrl__up_dwn, cntrl__ena, cntrl__load, err_pulse, err_sticky} !== 5'b10000) begin
            bad++;
            $display("FAIL rstmid_async outs=%b want 10000", {cntrl__up_dwn, cntrl__ena, cntrl__load, err_pulse, err_sticky});
        end
        enc_a = 1'b0;
        enc_b = 1'b0;
        enc_idx = 1'b0;
        cur_ab = 2'b00;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        t0 = cyc;
        repeat (30) tick();
        t1 = cyc;
        n = 0;
        for (int k = t0; k <= t1; k++) begin
            if ({obs_up[k], obs_ena[k], obs_ld[k], obs_err[k], obs_st[k]} !== 5'b10000) n++;
        end
        total++;
        if (n != 0) begin
            bad++;
            $display("FAIL rstmid_stale cycles_with_activity got %0d want 0", n);
        end
        model_dir = 1'b1;
        model_st = 1'b0;
    endtask

    initial begin
        test_reset();
        test_steps("up_steps", 2'b01, 2'b11, 2'b10, 2'b00);
        test_steps("down_steps", 2'b10, 2'b11, 2'b01, 2'b00);
        test_glitch();
        test_error();
        test_index();
        test_random_walk();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
